// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
package aes_pkg;
  localparam int NR_AES128 = 10;
  localparam int RND_W     = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYEXP,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_DONE
  } seq_state_t;
endpackage

// File: rtl/aes_round_sequencer_round_counter.sv
// Loadable up-counter with terminal-count compare; used for both round and key indices.
module round_counter
  import aes_pkg::*;
#(
  parameter int W = RND_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         inc_i,
  input  logic [W-1:0] tc_val_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i)       cnt_d = ld_val_i;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == tc_val_i);
endmodule

// File: rtl/aes_round_sequencer.sv
// AES-128 control FSM: key expansion, initial AddRoundKey, NR-1 rounds, final round,
// output handshake, with one buffered pending block and sticky overflow.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             key_rst,
  input  logic             out_ready,
  output logic             blk_capture,
  output logic             key_exp_en,
  output logic [RND_W-1:0] key_round,
  output logic [RND_W-1:0] round_num,
  output logic             rnd_en,
  output logic             rnd_first,
  output logic             rnd_last,
  output logic             out_valid,
  output logic             busy,
  output logic             key_valid,
  output logic             ovf
);
  localparam logic [RND_W-1:0] NR_L  = RND_W'(NR);
  localparam logic [RND_W-1:0] NR_M1 = RND_W'(NR - 1);

  seq_state_t       state_q, state_d;
  logic             load_pend_q, load_pend_d;
  logic             key_pend_q, key_pend_d;
  logic             key_valid_q, key_valid_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, busy_q;
  logic             start;

  logic             rc_ld, rc_inc, rc_tc;
  logic [RND_W-1:0] rc_cnt;
  logic             kc_ld, kc_inc, kc_tc;
  logic [RND_W-1:0] kc_ld_val, kc_cnt;

  round_counter #(.W(RND_W)) u_rnd_cnt (
    .clk      (clk),
    .rst      (rst),
    .ld_i     (rc_ld),
    .ld_val_i ('0),
    .inc_i    (rc_inc),
    .tc_val_i (NR_M1),
    .cnt_o    (rc_cnt),
    .tc_o     (rc_tc)
  );

  round_counter #(.W(RND_W)) u_key_cnt (
    .clk      (clk),
    .rst      (rst),
    .ld_i     (kc_ld),
    .ld_val_i (kc_ld_val),
    .inc_i    (kc_inc),
    .tc_val_i (NR_L),
    .cnt_o    (kc_cnt),
    .tc_o     (kc_tc)
  );

  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    rc_ld      = 1'b0;
    rc_inc     = 1'b0;
    kc_ld      = 1'b0;
    kc_ld_val  = '0;
    kc_inc     = 1'b0;
    key_exp_en = 1'b0;
    rnd_en     = 1'b0;
    rnd_first  = 1'b0;
    rnd_last   = 1'b0;
    unique case (state_q)
      // A new key always takes precedence over waiting plaintext.
      S_IDLE: begin
        if (key_pend_q || key_rst) begin
          state_d   = S_KEYEXP;
          kc_ld     = 1'b1;
          kc_ld_val = RND_W'(1);
        end else if ((load || load_pend_q) && key_valid_q) begin
          state_d = S_INIT;
          start   = 1'b1;
          rc_ld   = 1'b1;
        end
      end
      S_KEYEXP: begin
        key_exp_en = 1'b1;
        if (kc_tc) begin
          state_d = S_IDLE;
          kc_ld   = 1'b1;
        end else begin
          kc_inc = 1'b1;
        end
      end
      S_INIT: begin
        rnd_en    = 1'b1;
        rnd_first = 1'b1;
        rc_inc    = 1'b1;
        state_d   = S_ROUND;
      end
      S_ROUND: begin
        rnd_en = 1'b1;
        rc_inc = 1'b1;
        if (rc_tc) state_d = S_FINAL;
      end
      S_FINAL: begin
        rnd_en   = 1'b1;
        rnd_last = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          rc_ld   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_pend_d = load_pend_q;
    ovf_d       = ovf_q;
    key_pend_d  = key_pend_q;
    key_valid_d = key_valid_q;
    if (start) load_pend_d = 1'b0;
    // Only one block can wait; a strobe arriving while one waits is lost.
    if (load) begin
      if (load_pend_q) ovf_d = 1'b1;
      else if (!start) load_pend_d = 1'b1;
    end
    if (state_q == S_KEYEXP && kc_tc) begin
      key_pend_d  = 1'b0;
      key_valid_d = 1'b1;
    end
    if (key_rst) begin
      key_pend_d  = 1'b1;
      key_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      load_pend_q <= 1'b0;
      key_pend_q  <= 1'b0;
      key_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_pend_q <= load_pend_d;
      key_pend_q  <= key_pend_d;
      key_valid_q <= key_valid_d;
      ovf_q       <= ovf_d;
      out_valid_q <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign blk_capture = start;
  assign key_round   = kc_cnt;
  assign round_num   = rc_cnt;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign key_valid   = key_valid_q;
  assign ovf         = ovf_q;
endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Control FSM that sequences the AES-128 encryption datapath once the input front end has assembled a 128-bit block. It consumes the block-ready (`load`) and key-reset (`key_rst`) strobes from the input control path. It runs key expansion, then the initial AddRoundKey, nine full rounds and the final round. It holds the result until the output stage accepts it. One pending block is buffered so the input path can deliver the next block while the current one is in flight.

## Interface
- `NR`, 10, number of cipher rounds; `round_num` width is fixed at 4 bits, NR ≤ 15
- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `load`  in  1  one-cycle strobe: a plaintext block is stable on the input buses
- `key_rst`  in  1  one-cycle strobe: a new cipher key is stable; the expanded key must be regenerated
- `out_ready`  in  1  downstream accepts the ciphertext this cycle
- `blk_capture`  out  1  one-cycle strobe: datapath registers the input block into the state register
- `key_exp_en`  out  1  key-expansion step enable
- `key_round`  out  4  round-key index being generated (1..NR) while `key_exp_en`=1, else 0
- `round_num`  out  4  round-key index applied this cycle (0..NR)
- `rnd_en`  out  1  state register updates this cycle
- `rnd_first`  out  1  AddRoundKey only (round 0)
- `rnd_last`  out  1  final round (no MixColumns)
- `out_valid`  out  1  ciphertext valid; held until `out_ready`
- `busy`  out  1  FSM not in IDLE
- `key_valid`  out  1  expanded key schedule is complete
- `ovf`  out  1  sticky: a `load` was dropped; cleared only by reset

## Operation
- States: IDLE, KEYEXP, INIT, ROUND, FINAL, DONE.
- Reset: state IDLE. All outputs are 0, including `key_valid`. Counters and pending flags are cleared.
- `load_pend` flag:
  - Set by `load` in any state except IDLE with an immediate start.
  - If `load` arrives while `load_pend`=1, the strobe is dropped and `ovf` is set.
- `key_pend` flag:
  - Set by `key_rst` in any state.
  - `key_rst` also clears `key_valid` immediately (next edge).
- IDLE priority:
  - `key_pend` (or `key_rst` this cycle) → KEYEXP.
  - Otherwise, `load` or `load_pend`, with `key_valid`=1 → INIT and `blk_capture`=1.
  - A load without a valid key stays pending.
- KEYEXP: NR cycles, `key_exp_en`=1, `key_round` counts 1..NR. On exit `key_valid`=1, `key_pend`=0, return to IDLE.
- INIT: `round_num`=0, `rnd_en`=1, `rnd_first`=1 → ROUND.
- ROUND: `round_num` counts 1..NR-1, `rnd_en`=1. After NR-1 → FINAL.
- FINAL: `round_num`=NR, `rnd_en`=1, `rnd_last`=1 → DONE.
- DONE: `out_valid`=1. On `out_valid && out_ready` → IDLE.
- `key_rst` during INIT/ROUND/FINAL/DONE:
  - The current block completes with the old schedule.
  - Key expansion runs at the next IDLE, before any pending load.
- `load` in DONE: buffered in `load_pend`, not captured until IDLE.

## Timing
- `load` at edge t in IDLE (key valid): `blk_capture` at cycle t.
- Round sequence:
  - INIT at t+1.
  - ROUND at t+2..t+NR.
  - FINAL at t+NR+1.
  - `out_valid` from t+NR+2.
  - Latency is NR+2 cycles (12 for NR=10).
- Accepted at cycle u → IDLE at u+1. A pending load starts INIT at u+2, so block throughput is NR+3 cycles.
- `key_rst` at t in IDLE: KEYEXP at t+1..t+NR, `key_valid`=1 from t+NR+1. A pending load then captures at t+NR+1.
- `out_valid` and `busy` are registered outputs (Moore). `blk_capture` is a decode of state and inputs in IDLE.
- Reset asserted mid-operation: outputs go to 0 asynchronously. The block in flight is lost and `key_valid`=0.

## Structure
- Shared package `aes_pkg`: state enum `seq_state_t`, `NR_AES128`=10, round-index width constant `RND_W`=4.
- One sub-module `round_counter`: loadable 4-bit up-counter with terminal-count compare. Instantiated twice, once for `round_num` and once for `key_round`.
- The FSM, pending flags and the sticky `ovf` stay in the top.

## Test plan
- Reset, then `key_rst`. Check `key_exp_en` high for exactly 10 cycles with `key_round` 1..10, then `key_valid`=1.
- `load` at t with `out_ready`=1. Check:
  - `blk_capture` at t.
  - `rnd_first` at t+1.
  - `round_num` 1..9 at t+2..t+10.
  - `rnd_last` at t+11.
  - `out_valid` at t+12.
  - `busy` low at t+13.
- `load` before any key: no capture. Then `key_rst` → expansion completes → capture on the first cycle with `key_valid`=1.
- Two loads during one encryption: the first is pending and starts 2 cycles after accept; the second sets `ovf`=1, which stays set.
- `out_ready`=0 for 5 cycles in DONE. Check that `out_valid` holds and `round_num` is stable.
- `key_rst` at round 5: the current block finishes, KEYEXP runs before the pending load. Separately, `rst` at round 5 forces all outputs to 0 and `key_valid`=0.
